// File: rtl/data_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_pkg
// Shared types for the data-blockram arbiter:
//   arb_state_e : sequencer state (ARB, B_BURST)
//   owner_e     : which requester a read belongs to (OWN_A, OWN_B)
//   rd_tag_t    : registered read tag {valid, owner}
//   cnt_width() : width of a counter that must hold 0..max_val
// ---------------------------------------------------------------------------
package data_mem_arbiter_pkg;

  typedef enum logic {
    ARB     = 1'b0,
    B_BURST = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_if
// Bundles both requester ports and the blockram port of the arbiter.
//   a_* : CPU data path (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   b_* : bulk engine, same as A plus b_lock to hold the port
//   mem_* : single-port blockram (read data arrives one cycle after address)
// Modports:
//   slave  : the arbiter side
//   master : requesters plus blockram (testbench / surrounding fabric)
// ---------------------------------------------------------------------------
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_lock;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata, b_lock,
    output b_gnt, b_rvalid, b_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata, b_lock,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Arbitrates the single data-blockram port between requester A (CPU data
// path) and requester B (bulk engine), tags reads so the one-cycle-late
// blockram data is flagged for the right owner, bounds how long A may starve
// B, and lets B hold the port for short locked bursts.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : data_mem_arbiter_if.slave (A, B and blockram signals)
//
// state   | meaning
// --------+---------------------------------------------------------------
// ARB     | normal arbitration; B only beats a waiting A when starved
// B_BURST | B holds the port while it keeps requesting, up to B_MAX_BURST
// ---------------------------------------------------------------------------
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int B_MAX_BURST  = 8
) (
  input logic                clk,
  input logic                rst_n,
  data_mem_arbiter_if.slave  bus
);

  localparam int SW = cnt_width(STARVE_LIMIT);
  localparam int BW = cnt_width(B_MAX_BURST);

  arb_state_e   state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          force_a_q, force_a_d;
  rd_tag_t       tag_q, tag_d;

  logic          gnt_a, gnt_b;
  logic          starve_full;
  logic [BW-1:0] burst_inc;
  logic          burst_full;

  assign starve_full = (starve_q == SW'(STARVE_LIMIT));
  assign burst_inc   = burst_q + 1'b1;
  assign burst_full  = (burst_inc == BW'(B_MAX_BURST));

  // Grants are combinational; they are held off while reset is asserted so
  // nothing reaches the blockram during reset even with requests pending.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      if (state_q == B_BURST) begin
        gnt_b = bus.b_req;
      end else begin
        // force_a_q gives A the first cycle after a full burst
        gnt_b = bus.b_req && (!bus.a_req || (starve_full && !force_a_q));
        gnt_a = bus.a_req && !gnt_b;
      end
    end
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    if (gnt_a) begin
      bus.mem_addr  = bus.a_addr;
      bus.mem_wdata = bus.a_wdata;
      bus.mem_we    = bus.a_we;
    end else if (gnt_b) begin
      bus.mem_addr  = bus.b_addr;
      bus.mem_wdata = bus.b_wdata;
      bus.mem_we    = bus.b_we;
    end
  end

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    force_a_d = 1'b0;
    case (state_q)
      ARB: begin
        if (gnt_b && bus.b_lock && (B_MAX_BURST > 1)) begin
          state_d = B_BURST;
          burst_d = BW'(1);
        end
      end
      B_BURST: begin
        if (!gnt_b) begin
          state_d = ARB;
          burst_d = '0;
        end else if (burst_full || !bus.b_lock) begin
          state_d   = ARB;
          burst_d   = '0;
          force_a_d = burst_full;
        end else begin
          burst_d = burst_inc;
        end
      end
      default: begin
        state_d = ARB;
        burst_d = '0;
      end
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (gnt_b || !bus.b_req) begin
      starve_d = '0;
    end else if (gnt_a && !starve_full) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    tag_d.valid = (gnt_a && !bus.a_we) || (gnt_b && !bus.b_we);
    tag_d.owner = gnt_b ? OWN_B : OWN_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB;
      starve_q  <= '0;
      burst_q   <= '0;
      force_a_q <= 1'b0;
      tag_q     <= '{valid: 1'b0, owner: OWN_A};
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      burst_q   <= burst_d;
      force_a_q <= force_a_d;
      tag_q     <= tag_d;
    end
  end

  assign bus.a_gnt    = gnt_a;
  assign bus.b_gnt    = gnt_b;
  assign bus.a_rvalid = tag_q.valid && (tag_q.owner == OWN_A);
  assign bus.b_rvalid = tag_q.valid && (tag_q.owner == OWN_B);
  assign bus.a_rdata  = bus.mem_rdata;
  assign bus.b_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed scenarios followed by a randomized phase. A behavioural model
// (grant rules, shadow memory, expected read returns) predicts every cycle.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LIM  = 4;
  localparam int BMAX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM), .B_MAX_BURST(BMAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // blockram environment: write on edge, registered read
  bit [15:0] env_mem [65536];
  bit        env_wr  [65536];
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      env_mem[bus.mem_addr] <= bus.mem_wdata;
      env_wr[bus.mem_addr]  <= 1'b1;
    end
    bus.mem_rdata <= env_wr[bus.mem_addr] ? env_mem[bus.mem_addr] : dflt(bus.mem_addr);
  end

  // reference model
  bit [15:0] ref_mem [65536];
  bit        ref_wr  [65536];
  bit        m_burst, m_force, p_rd, p_owner_b;
  int        m_beats, m_starve;
  logic [15:0] p_data;

  // requester intent
  int          a_left, b_left;
  bit          a_we_r, b_we_r, b_lock_r;
  logic [15:0] a_addr_r, a_wdata_r, b_addr_r, b_wdata_r;

  int vecs = 0;
  int errs = 0;
  int trace[$];
  logic        obs_we;
  logic [15:0] obs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : dflt(a);
  endfunction

  task automatic cycle();
    bit ar, br, ga, gb, nforce, ewe;
    logic [15:0] eaddr, edata;
    @(posedge clk);
    #1;
    bus.a_req   = (a_left > 0);
    bus.a_we    = a_we_r;
    bus.a_addr  = a_addr_r;
    bus.a_wdata = a_wdata_r;
    bus.b_req   = (b_left > 0);
    bus.b_we    = b_we_r;
    bus.b_addr  = b_addr_r;
    bus.b_wdata = b_wdata_r;
    bus.b_lock  = b_lock_r;
    @(negedge clk);
    ar = (a_left > 0);
    br = (b_left > 0);
    if (m_burst) begin
      gb = br;
      ga = 1'b0;
    end else begin
      gb = br && (!ar || (m_starve >= LIM && !m_force));
      ga = ar && !gb;
    end
    ewe = 1'b0; eaddr = 16'h0; edata = 16'h0;
    if (ga) begin ewe = a_we_r; eaddr = a_addr_r; edata = a_wdata_r; end
    else if (gb) begin ewe = b_we_r; eaddr = b_addr_r; edata = b_wdata_r; end
    chk("a_gnt", bus.a_gnt, ga);
    chk("b_gnt", bus.b_gnt, gb);
    chk("mem_we", bus.mem_we, ewe);
    chk("mem_addr", bus.mem_addr, eaddr);
    chk("mem_wdata", bus.mem_wdata, edata);
    chk("a_rvalid", bus.a_rvalid, p_rd && !p_owner_b);
    chk("b_rvalid", bus.b_rvalid, p_rd && p_owner_b);
    if (p_rd && !p_owner_b) chk("a_rdata", bus.a_rdata, p_data);
    if (p_rd && p_owner_b)  chk("b_rdata", bus.b_rdata, p_data);
    obs_we = bus.mem_we;
    obs_addr = bus.mem_addr;
    // model update
    if ((ga || gb) && ewe) begin
      ref_mem[eaddr] = edata;
      ref_wr[eaddr] = 1'b1;
    end
    p_rd = (ga || gb) && !ewe;
    p_owner_b = gb;
    p_data = ref_rd(eaddr);
    if (gb || !br) m_starve = 0;
    else if (ga && m_starve < LIM) m_starve++;
    nforce = 1'b0;
    if (!m_burst) begin
      if (gb && b_lock_r && BMAX > 1) begin m_burst = 1'b1; m_beats = 1; end
    end else if (!gb) begin
      m_burst = 1'b0; m_beats = 0;
    end else begin
      m_beats++;
      if (m_beats == BMAX) begin nforce = 1'b1; m_burst = 1'b0; m_beats = 0; end
      else if (!b_lock_r) begin m_burst = 1'b0; m_beats = 0; end
    end
    m_force = nforce;
    trace.push_back(ga ? 1 : (gb ? 2 : 0));
    if (ga) begin a_left--; a_addr_r++; a_wdata_r++; end
    if (gb) begin b_left--; b_addr_r++; b_wdata_r++; end
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while ((a_left > 0 || b_left > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_done"}, (a_left > 0 || b_left > 0), 1'b0);
  endtask

  task automatic do_reset(input bit mid_cycle);
    if (mid_cycle) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    bus.a_req = 1'b1;
    bus.b_req = 1'b1;
    #1;
    chk("rst_a_gnt", bus.a_gnt, 1'b0);
    chk("rst_b_gnt", bus.b_gnt, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0);
    chk("rst_a_rvalid", bus.a_rvalid, 1'b0);
    chk("rst_b_rvalid", bus.b_rvalid, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_a_gnt", bus.a_gnt, 1'b0);
    chk("rst_hold_b_gnt", bus.b_gnt, 1'b0);
    chk("rst_hold_b_rvalid", bus.b_rvalid, 1'b0);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    a_left = 0; b_left = 0; b_lock_r = 1'b0;
    m_burst = 1'b0; m_force = 1'b0; m_beats = 0; m_starve = 0; p_rd = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int nb;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0; bus.b_lock = 0;
    a_we_r = 0; b_we_r = 0; a_addr_r = 0; b_addr_r = 0; a_wdata_r = 0; b_wdata_r = 0;
    #7;
    // reset with both requests active, then first grant goes to A
    do_reset(1'b0);
    trace.delete();
    a_left = 1; a_we_r = 0; a_addr_r = 16'h0004;
    b_left = 1; b_we_r = 0; b_addr_r = 16'h0008; b_lock_r = 0;
    run_until_idle("rst_release", 10);
    chk("rst_first_gnt", trace[0], 1);
    cycle();

    // starvation: A,A,A,A,B repeating
    trace.delete();
    a_left = 12; a_we_r = 0; a_addr_r = 16'h0000;
    b_left = 3;  b_we_r = 0; b_addr_r = 16'h0001; b_lock_r = 0;
    run_until_idle("starve", 40);
    chk("starve_b0", trace[4], 2);
    chk("starve_b1", trace[9], 2);
    chk("starve_b2", trace[14], 2);
    chk("starve_len", trace.size(), 15);
    cycle();

    // read return: preload, then A read followed by B read
    a_left = 1; a_we_r = 1; a_addr_r = 16'h0010; a_wdata_r = 16'h1234;
    b_left = 1; b_we_r = 1; b_addr_r = 16'h0020; b_wdata_r = 16'hBEEF;
    run_until_idle("preload", 10);
    a_left = 1; a_we_r = 0; a_addr_r = 16'h0010;
    cycle();
    b_left = 1; b_we_r = 0; b_addr_r = 16'h0020;
    cycle();
    chk("rd_a_valid", bus.a_rvalid, 1'b1);
    chk("rd_a_data", bus.a_rdata, 16'h1234);
    chk("rd_a_b_quiet", bus.b_rvalid, 1'b0);
    cycle();
    chk("rd_b_valid", bus.b_rvalid, 1'b1);
    chk("rd_b_data", bus.b_rdata, 16'hBEEF);
    chk("rd_b_a_quiet", bus.a_rvalid, 1'b0);

    // locked burst: 8 B writes, one A, then B resumes
    trace.delete();
    b_left = 11; b_we_r = 1; b_addr_r = 16'h0100; b_wdata_r = 16'h7000; b_lock_r = 1;
    cycle();
    a_left = 1; a_we_r = 0; a_addr_r = 16'h0040;
    run_until_idle("burst", 40);
    nb = 0;
    for (int i = 0; i < 8; i++) if (trace[i] == 2) nb++;
    chk("burst_b_beats", nb, 8);
    chk("burst_a_slot", trace[8], 1);
    chk("burst_b_resume", trace[9], 2);
    b_lock_r = 0;
    cycle();

    // write path
    a_left = 1; a_we_r = 1; a_addr_r = 16'h3FF0; a_wdata_r = 16'hCAFE;
    cycle();
    chk("wr_mem_we", obs_we, 1'b1);
    chk("wr_mem_addr", obs_addr, 16'h3FF0);
    cycle();
    a_left = 1; a_we_r = 0; a_addr_r = 16'h3FF0;
    cycle();
    cycle();
    chk("wr_readback_valid", bus.a_rvalid, 1'b1);
    chk("wr_readback_data", bus.a_rdata, 16'hCAFE);

    // mid-read reset: B read granted, reset next cycle kills rvalid
    b_left = 1; b_we_r = 0; b_addr_r = 16'h0020; b_lock_r = 0;
    cycle();
    do_reset(1'b1);
    trace.delete();
    a_left = 5; a_we_r = 0; a_addr_r = 16'h0002;
    b_left = 1; b_we_r = 0; b_addr_r = 16'h0003;
    run_until_idle("post_rst", 20);
    chk("post_rst_a_first", trace[0], 1);
    chk("post_rst_b_slot", trace[4], 2);
    cycle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (trace.size() > 0 && trace[$] == 2) b_lock_r = ($urandom_range(0, 3) != 0);
      if (a_left == 0 && $urandom_range(0, 2) == 0) begin
        a_left = 1;
        a_we_r = $urandom_range(0, 1);
        a_addr_r = 16'($urandom_range(0, 15));
        a_wdata_r = 16'($urandom);
      end
      if (b_left == 0 && $urandom_range(0, 4) == 0) begin
        b_left = $urandom_range(1, 10);
        b_we_r = $urandom_range(0, 1);
        b_addr_r = 16'($urandom_range(0, 15));
        b_wdata_r = 16'($urandom);
        b_lock_r = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end
    run_until_idle("rand_drain", 200);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
